integer_product_formatter: RTL

INTEGER_PRODUCT_FORMATTER -- requirements
Module: integer_product_formatter

---
 rtl/integer_product_formatter_if.sv | 49 ++++
 rtl/integer_product_formatter.sv | 112 +++++++++++
 2 files changed

// File: rtl/integer_product_formatter_if.sv
// ============================================================================
// Module      : integer_product_formatter_if
// Description : Handshake/bus bundle between the multiplier (master side) and
//               the product formatter (slave side). When the macro
//               INTEGER_PRODUCT_FORMATTER_OVERFLOW_FLAG_EN is defined, the
//               per-result overflow flag is carried as well.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface integer_product_formatter_if #(
  parameter int PRODUCT_WIDTH_IN_BITS = 64,
  parameter int QUEUE_DEPTH           = 4
);
  localparam int c_CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                             product_valid_in;
  logic                             product_sign_in;
  logic [PRODUCT_WIDTH_IN_BITS-1:0] product_in;
  logic                             issue_ack_out;
  logic                             result_valid_out;
  logic [PRODUCT_WIDTH_IN_BITS-1:0] result_out;
  logic                             result_ready_in;
  logic [c_CNT_W-1:0]               queue_count_out;
`ifdef INTEGER_PRODUCT_FORMATTER_OVERFLOW_FLAG_EN
  logic                             result_overflow_out;
`endif

  // Producer/consumer side driving the formatter
  modport master (
    output product_valid_in, product_sign_in, product_in, result_ready_in,
`ifdef INTEGER_PRODUCT_FORMATTER_OVERFLOW_FLAG_EN
    input  result_overflow_out,
`endif
    input  issue_ack_out, result_valid_out, result_out, queue_count_out
  );

  // Formatter side
  modport slave (
    input  product_valid_in, product_sign_in, product_in, result_ready_in,
`ifdef INTEGER_PRODUCT_FORMATTER_OVERFLOW_FLAG_EN
    output result_overflow_out,
`endif
    output issue_ack_out, result_valid_out, result_out, queue_count_out
  );

endinterface

`default_nettype wire

// File: rtl/integer_product_formatter.sv
// ============================================================================
// Module      : integer_product_formatter
// Description : Captures sign/magnitude products from a multiplier, converts
//               them to two's complement and holds them in a small FIFO for
//               the consumer. Each accepted product is acknowledged with a
//               single-cycle issue_ack_out pulse.
//               Optional macro INTEGER_PRODUCT_FORMATTER_OVERFLOW_FLAG_EN adds
//               a per-entry overflow flag aligned with result_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module integer_product_formatter #(
  parameter int PRODUCT_WIDTH_IN_BITS = 64,
  parameter int QUEUE_DEPTH           = 4
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  integer_product_formatter_if.slave   ipf_bus
);

  localparam int c_W     = PRODUCT_WIDTH_IN_BITS;
  localparam int c_MSB   = PRODUCT_WIDTH_IN_BITS - 1;
  localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(QUEUE_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_W-1:0]     c_ONE     = c_W'(1);

  logic [c_W-1:0]     r_data_mem [QUEUE_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_ack;

  logic               w_full;
  logic               w_empty;
  logic               w_capture;
  logic               w_pop;
  logic [c_W-1:0]     w_formatted;

  // Full comes from the occupancy count: pointers alone are ambiguous when equal
  assign w_full    = (r_count == c_DEPTH);
  assign w_empty   = (r_count == '0);

  // The cycle carrying the ack still sees valid high from upstream, so block it
  assign w_capture = ipf_bus.product_valid_in & ~r_ack & ~w_full;
  assign w_pop     = ~w_empty & ipf_bus.result_ready_in;

  assign w_formatted = ipf_bus.product_sign_in ? ((~ipf_bus.product_in) + c_ONE)
                                               : ipf_bus.product_in;

  // Storage write; entries need no reset since validity is tracked by r_count
  always_ff @(posedge clk_in) begin
    if (w_capture) begin
      r_data_mem[r_wr_ptr] <= w_formatted;
    end
  end

  // Pointers, occupancy and the one-cycle accept pulse
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= w_capture;
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ipf_bus.issue_ack_out    = r_ack;
  assign ipf_bus.result_valid_out = ~w_empty;
  assign ipf_bus.result_out       = r_data_mem[r_rd_ptr];
  assign ipf_bus.queue_count_out  = r_count;

`ifdef INTEGER_PRODUCT_FORMATTER_OVERFLOW_FLAG_EN
  logic r_ovf_mem [QUEUE_DEPTH];
  logic w_formatted_ovf;

  // Positive results need the MSB clear; negative ones may reach exactly -2^(W-1)
  assign w_formatted_ovf = ipf_bus.product_sign_in
                         ? (ipf_bus.product_in[c_MSB] & (|ipf_bus.product_in[c_MSB-1:0]))
                         : ipf_bus.product_in[c_MSB];

  // Overflow flag stored alongside its data entry
  always_ff @(posedge clk_in) begin
    if (w_capture) begin
      r_ovf_mem[r_wr_ptr] <= w_formatted_ovf;
    end
  end

  // Masked by occupancy so the flag reads 0 out of reset and while empty
  assign ipf_bus.result_overflow_out = ~w_empty & r_ovf_mem[r_rd_ptr];
`endif

endmodule

`default_nettype wire
